// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types and constants for the reset sequencer
// Purpose: state encoding, lock glitch filter length and parameter clamp helper.
// Ports: none (package).
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_LOCK_WAIT = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_e;

    // Consecutive synced-low cycles that count as a real lock loss when filtering.
    localparam int unsigned LOCK_FILTER_LEN = 4;

    // A zero-length interval would never expire on a down-counter; run it as one cycle.
    function automatic logic [31:0] at_least_one(input int unsigned v);
        return (v == 0) ? 32'd1 : v[31:0];
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_sync_filter.sv
// rtl/reset_sequencer_lock_sync_filter.sv - pll_lock synchronizer with optional glitch filter
// Purpose: brings the asynchronous PLL lock into clk and flags lock loss.
//   Optional feature macro: RESET_SEQ_LOCK_FILTER_EN (loss needs LOCK_FILTER_LEN consecutive lows).
// Ports: clk, rst_in (async, active-high), pll_lock (async in),
//   lock_ok (synced lock), lock_lost (loss event as seen by the sequencer).
module lock_sync_filter
    import reset_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_in,
    input  logic pll_lock,
    output logic lock_ok,
    output logic lock_lost
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lock_ok = sync_q[1];

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int unsigned LOW_W = $clog2(LOCK_FILTER_LEN);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(LOCK_FILTER_LEN - 1);

    logic [LOW_W-1:0] low_cnt_q;
    logic [LOW_W-1:0] low_cnt_d;

    // Counts consecutive synced-low cycles; any high sample restarts the run.
    always_comb begin
        low_cnt_d = '0;
        if (!sync_q[1]) begin
            low_cnt_d = (low_cnt_q == LOW_MAX) ? LOW_MAX : low_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            low_cnt_q <= '0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    // Fires on the LOCK_FILTER_LEN-th consecutive low cycle and stays while low.
    assign lock_lost = !sync_q[1] && (low_cnt_q == LOW_MAX);
`else
    assign lock_lost = !sync_q[1];
`endif

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - supervised PLL bring-up and staggered domain reset release
// Purpose: PLL reset pulse, lock wait with timeout/retries, settle, staggered release, run.
//   Optional feature macro: RESET_SEQ_LOCK_FILTER_EN (see lock_sync_filter).
// Ports: clk, rst_in (async, active-high), wakeup (0 = restart), pll_lock (async),
//   pll_rst, domain_rst[N_DOMAINS], n_ready (0 = running), fault, retry_cnt, state_dbg.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned N_DOMAINS      = 3,
    parameter int unsigned PLL_RST_CYCLES = 65536,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned SETTLE_CYCLES  = 33554432,
    parameter int unsigned STAGGER_CYCLES = 256,
    parameter int unsigned MAX_RETRIES    = 3,
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 wakeup,
    input  logic                 pll_lock,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 n_ready,
    output logic                 fault,
    output logic [RW-1:0]        retry_cnt,
    output logic [2:0]           state_dbg
);

    // Down-counter reload values: a state lasts (load + 1) cycles.
    localparam logic [31:0] PLL_LOAD     = at_least_one(PLL_RST_CYCLES) - 32'd1;
    localparam logic [31:0] TIMEOUT_LOAD = at_least_one(LOCK_TIMEOUT) - 32'd1;
    localparam logic [31:0] SETTLE_LOAD  = at_least_one(SETTLE_CYCLES) - 32'd1;
    localparam logic [31:0] STAGGER_V    = at_least_one(STAGGER_CYCLES);
    localparam logic [31:0] REL_LOAD     = 32'(N_DOMAINS) * STAGGER_V - 32'd1;
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    logic lock_ok;
    logic lock_lost;

    lock_sync_filter u_lock (
        .clk       (clk),
        .rst_in    (rst_in),
        .pll_lock  (pll_lock),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
    );

    seq_state_e           state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 pll_rst_q, pll_rst_d;
    logic [N_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                 n_ready_q, n_ready_d;
    logic                 fault_q, fault_d;
    logic [RW-1:0]        retry_q, retry_d;

    function automatic logic [31:0] load_for(input seq_state_e s);
        case (s)
            ST_PLL_RST:   return PLL_LOAD;
            ST_LOCK_WAIT: return TIMEOUT_LOAD;
            ST_SETTLE:    return SETTLE_LOAD;
            ST_RELEASE:   return REL_LOAD;
            default:      return 32'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (wakeup) state_d = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (cnt_q == 32'd0) state_d = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                // Lock is tested first so a lock arriving on the timeout edge wins.
                if (lock_ok) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == 32'd0) begin
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
                    state_d = (retry_q == RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_SETTLE: begin
                if (lock_lost)            state_d = ST_PLL_RST;
                else if (cnt_q == 32'd0)  state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (lock_lost)            state_d = ST_PLL_RST;
                else if (cnt_q == 32'd0)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (lock_lost) state_d = ST_PLL_RST;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Wakeup low overrides every other transition.
        if (!wakeup) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end

        if (state_d != state_q) begin
            cnt_d = load_for(state_d);
        end
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            retry_d = '0;
        end

        // Outputs are registered from the next state so they align with state_q.
        pll_rst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        fault_d   = (state_d == ST_FAULT);
        n_ready_d = (state_d != ST_RUN);
        domain_rst_d = '1;
        if (state_d == ST_RUN) begin
            domain_rst_d = '0;
        end else if (state_d == ST_RELEASE) begin
            // Domain i is released once (REL_LOAD - cnt) elapsed cycles reach i*STAGGER.
            for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                domain_rst_d[i] = (cnt_d > REL_LOAD - i * STAGGER_V);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            n_ready_q    <= 1'b1;
            fault_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            n_ready_q    <= n_ready_d;
            fault_q      <= fault_d;
            retry_q      <= retry_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign domain_rst = domain_rst_q;
    assign n_ready    = n_ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       wakeup;
    logic       pll_lock;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       n_ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_DOMAINS      (3),
        .PLL_RST_CYCLES (8),
        .LOCK_TIMEOUT   (32),
        .SETTLE_CYCLES  (16),
        .STAGGER_CYCLES (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .wakeup     (wakeup),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .domain_rst (domain_rst),
        .n_ready    (n_ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg)
    );

    // Counts negedges until state_dbg equals target; returns max+1 on timeout.
    task automatic wait_state(input logic [2:0] target, input int max, output int cycles);
        cycles = 0;
        while (cycles <= max) begin
            @(negedge clk);
            cycles++;
            if (state_dbg == target) return;
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1; wakeup = 1'b0; pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL reset_domain got=%b want=111", domain_rst); end
        checks++; if (n_ready !== 1'b1) begin errors++; $display("FAIL reset_n_ready got=%b want=1", n_ready); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL idle_hold got=%0d want=0", state_dbg); end
    endtask

    task automatic test_nominal;
        int c;
        logic [2:0] exp_dom;
        wakeup = 1'b1;
        wait_state(3'd1, 4, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL nom_enter_pll_rst cycles=%0d want=1", c); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL nom_pll_rst_high got=%b want=1", pll_rst); end
        wait_state(3'd2, 20, c);
        checks++; if (c !== 8) begin errors++; $display("FAIL nom_pll_pulse cycles=%0d want=8", c); end
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL nom_pll_rst_low got=%b want=0", pll_rst); end
        repeat (10) @(negedge clk);
        pll_lock = 1'b1;
        wait_state(3'd3, 10, c);
        checks++; if (c !== 3) begin errors++; $display("FAIL nom_lock_sync cycles=%0d want=3", c); end
        wait_state(3'd4, 40, c);
        checks++; if (c !== 16) begin errors++; $display("FAIL nom_settle cycles=%0d want=16", c); end
        checks++; if (domain_rst !== 3'b110) begin errors++; $display("FAIL nom_rel_k0 got=%b want=110", domain_rst); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_dom = (k < 4) ? 3'b110 : (k < 8) ? 3'b100 : 3'b000;
            checks++; if (domain_rst !== exp_dom) begin errors++; $display("FAIL nom_rel_dom k=%0d got=%b want=%b", k, domain_rst, exp_dom); end
            checks++; if (n_ready !== (k < 12)) begin errors++; $display("FAIL nom_rel_n_ready k=%0d got=%b want=%b", k, n_ready, (k < 12)); end
        end
        checks++; if (state_dbg !== 3'd5) begin errors++; $display("FAIL nom_run got=%0d want=5", state_dbg); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL nom_fault got=%b want=0", fault); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL nom_retry got=%0d want=0", retry_cnt); end
    endtask

    task automatic test_lock_loss;
        int c;
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
`ifdef RESET_SEQ_LOCK_FILTER_EN
        repeat (6) @(negedge clk);
        checks++; if (state_dbg !== 3'd5) begin errors++; $display("FAIL loss_filtered_state got=%0d want=5", state_dbg); end
        checks++; if (n_ready !== 1'b0) begin errors++; $display("FAIL loss_filtered_n_ready got=%b want=0", n_ready); end
`else
        @(negedge clk);
        checks++; if (n_ready !== 1'b0) begin errors++; $display("FAIL loss_early_n_ready got=%b want=0", n_ready); end
        @(negedge clk);
        checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL loss_state got=%0d want=1", state_dbg); end
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL loss_domain got=%b want=111", domain_rst); end
        checks++; if (n_ready !== 1'b1) begin errors++; $display("FAIL loss_n_ready got=%b want=1", n_ready); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst got=%b want=1", pll_rst); end
        wait_state(3'd2, 20, c);
        checks++; if (c !== 8) begin errors++; $display("FAIL loss_pll_pulse cycles=%0d want=8", c); end
        wait_state(3'd5, 100, c);
        checks++; if (c !== 29) begin errors++; $display("FAIL loss_recover cycles=%0d want=29", c); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL loss_retry got=%0d want=0", retry_cnt); end
`endif
    endtask

    task automatic test_wakeup_drop;
        int c;
        wakeup = 1'b0;
        @(negedge clk);
        wakeup = 1'b1;
        wait_state(3'd4, 100, c);
        checks++; if (c !== 26) begin errors++; $display("FAIL wk_reach_release cycles=%0d want=26", c); end
        @(negedge clk);
        wakeup = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL wk_idle got=%0d want=0", state_dbg); end
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL wk_domain got=%b want=111", domain_rst); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL wk_pll_rst got=%b want=1", pll_rst); end
        checks++; if (n_ready !== 1'b1) begin errors++; $display("FAIL wk_n_ready got=%b want=1", n_ready); end
        wakeup = 1'b1;
        wait_state(3'd5, 100, c);
        checks++; if (c !== 38) begin errors++; $display("FAIL wk_restart cycles=%0d want=38", c); end
        checks++; if (domain_rst !== 3'b000) begin errors++; $display("FAIL wk_run_domain got=%b want=000", domain_rst); end
        checks++; if (n_ready !== 1'b0) begin errors++; $display("FAIL wk_run_n_ready got=%b want=0", n_ready); end
    endtask

    task automatic test_async_reset;
        int c;
        wakeup = 1'b0;
        @(negedge clk);
        wakeup = 1'b1;
        wait_state(3'd3, 40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL ar_reach_settle cycles=%0d want=10", c); end
        @(negedge clk);
        #1 rst_in = 1'b1;
        #1;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL ar_state got=%0d want=0", state_dbg); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL ar_pll_rst got=%b want=1", pll_rst); end
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL ar_domain got=%b want=111", domain_rst); end
        checks++; if (n_ready !== 1'b1) begin errors++; $display("FAIL ar_n_ready got=%b want=1", n_ready); end
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic test_timeout_retry;
        int c;
        logic [2:0] exp_next;
        logic [1:0] exp_retry;
        pll_lock = 1'b0;
        wait_state(3'd1, 4, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL to_enter cycles=%0d want=1", c); end
        for (int a = 0; a < 3; a++) begin
            exp_next  = (a == 2) ? 3'd6 : 3'd1;
            exp_retry = (a == 0) ? 2'd1 : 2'd2;
            wait_state(3'd2, 20, c);
            checks++; if (c !== 8) begin errors++; $display("FAIL to_pll_pulse a=%0d cycles=%0d want=8", a, c); end
            checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_low a=%0d got=%b want=0", a, pll_rst); end
            wait_state(exp_next, 40, c);
            checks++; if (c !== 32) begin errors++; $display("FAIL to_wait a=%0d cycles=%0d want=32", a, c); end
            checks++; if (retry_cnt !== exp_retry) begin errors++; $display("FAIL to_retry a=%0d got=%0d want=%0d", a, retry_cnt, exp_retry); end
        end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault got=%b want=1", fault); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL to_fault_pll_rst got=%b want=1", pll_rst); end
        repeat (5) @(negedge clk);
        checks++; if (state_dbg !== 3'd6) begin errors++; $display("FAIL to_fault_hold got=%0d want=6", state_dbg); end
        wakeup = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL to_exit_idle got=%0d want=0", state_dbg); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_exit_fault got=%b want=0", fault); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL to_exit_retry got=%0d want=0", retry_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_wakeup_drop();
        test_async_reset();
        test_timeout_retry();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and recovery sequencer for the SCROD USB standalone clocking and reset tree. It runs the USB PLL reset pulse, waits for lock with a timeout and bounded retries, and holds a settle interval. It then releases N downstream reset domains in a staggered order and asserts `n_ready` low once everything is up. It replaces ad-hoc free-running counters with one supervised FSM that also restarts on lock loss or a wakeup drop.

## Interface
Parameters:
- `N_DOMAINS`, 3: number of downstream reset domains
- `PLL_RST_CYCLES`, 65536: PLL reset pulse length
- `LOCK_TIMEOUT`, 1048576: maximum cycles to wait for lock per attempt
- `SETTLE_CYCLES`, 33554432: cycles lock must hold before release
- `STAGGER_CYCLES`, 256: spacing between domain releases
- `MAX_RETRIES`, 3: retries after the first attempt

Ports:
- `clk`  in  1  system clock (free-running, not PLL-derived)
- `rst_in`  in  1  reset, asynchronous, active-high
- `wakeup`  in  1  level; 0 forces restart, 1 enables sequencing
- `pll_lock`  in  1  PLL lock, asynchronous to `clk`
- `pll_rst`  out  1  PLL reset, active-high
- `domain_rst`  out  N_DOMAINS  per-domain reset, active-high
- `n_ready`  out  1  0 = system running
- `fault`  out  1  retries exhausted
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  failed attempts so far
- `state_dbg`  out  3  current state encoding

## Operation
- States: `IDLE`, `PLL_RST`, `LOCK_WAIT`, `SETTLE`, `RELEASE`, `RUN`, `FAULT`.
- **`IDLE`**
  - `pll_rst`=1, all `domain_rst`=1, `n_ready`=1.
  - Goes to `PLL_RST` on the first edge with `wakeup`=1.
- **`PLL_RST`**
  - `pll_rst`=1 for exactly `PLL_RST_CYCLES` cycles, then `LOCK_WAIT`.
- **`LOCK_WAIT`**
  - `pll_rst`=0.
  - Synced lock=1: go to `SETTLE`.
  - After `LOCK_TIMEOUT` cycles without lock: `retry_cnt`++.
    - If `retry_cnt` was already `MAX_RETRIES`, go to `FAULT`.
    - Otherwise go to `PLL_RST`.
- **`SETTLE`**
  - Lock must stay high for `SETTLE_CYCLES` consecutive cycles, then `RELEASE`.
- **`RELEASE`**
  - `domain_rst[i]` deasserts `i*STAGGER_CYCLES` cycles after `RELEASE` entry; index 0 goes first.
  - `(N_DOMAINS-1)*STAGGER_CYCLES + STAGGER_CYCLES` cycles after entry: go to `RUN`.
- **`RUN`**
  - `n_ready`=0; `retry_cnt` cleared on entry.
- **`FAULT`**
  - `fault`=1, `pll_rst`=1, all domains in reset.
  - Exits only via `wakeup`=0 (to `IDLE`) or `rst_in`.
- Lock loss in `SETTLE`, `RELEASE` or `RUN`:
  - All `domain_rst` reassert and `n_ready`=1 on the same edge the loss is detected.
  - Next state is `PLL_RST`; `retry_cnt` is unchanged.
- `wakeup`=0 in any state: `IDLE` on the next edge, all resets asserted, `retry_cnt` and `fault` cleared. This takes priority over every other transition.
- One shared 32-bit down-counter serves all timed states and is reloaded on every state entry. Parameter value 0 is treated as 1.
- `retry_cnt` saturates at `MAX_RETRIES`.

## Timing
- Reset values: state `IDLE`, `pll_rst`=1, `domain_rst`=all 1, `n_ready`=1, `fault`=0, `retry_cnt`=0, `state_dbg`=`IDLE`.
- All outputs are registered and change only on `clk` rising edges (`rst_in` excepted).
- `pll_lock` passes through a 2-flop synchronizer, so transitions are seen 2 cycles late.
- `wakeup` is treated as synchronous.
- An `rst_in` assertion mid-sequence forces reset values immediately (asynchronously).
- If lock rises on the same edge that `LOCK_WAIT` times out, lock wins.

## Configuration
- `RESET_SEQ_LOCK_FILTER_EN` defined:
  - A synced lock low must persist 4 consecutive cycles before it counts as lock loss in `SETTLE`/`RELEASE`/`RUN`.
  - A shorter low pulse is ignored, and `SETTLE` counting continues.
- Undefined: a single synced low cycle counts as loss.

## Structure
- Package `reset_seq_pkg`:
  - State enum with fixed 3-bit encodings: `IDLE`=0, `PLL_RST`=1, `LOCK_WAIT`=2, `SETTLE`=3, `RELEASE`=4, `RUN`=5, `FAULT`=6.
  - Filter length constant (4).
- Sub-module `lock_sync_filter`: 2-flop synchronizer plus the optional glitch filter; outputs `lock_ok` and `lock_lost`.

## Test plan
Bench parameters: `N_DOMAINS`=3, `PLL_RST_CYCLES`=8, `LOCK_TIMEOUT`=32, `SETTLE_CYCLES`=16, `STAGGER_CYCLES`=4, `MAX_RETRIES`=2.
- Nominal bring-up:
  - Stimulus: `wakeup`=1; lock rises 10 cycles into `LOCK_WAIT`.
  - Required: `pll_rst` high 8 cycles after `IDLE`; domains release at 0/4/8 cycles after `RELEASE` entry; `n_ready` falls 12 cycles after `RELEASE` entry; `fault`=0.
- Timeout retry:
  - Stimulus: lock held low.
  - Required: three 8-cycle `pll_rst` pulses separated by 32-cycle waits; `retry_cnt` reads 1, 2, 2; `FAULT` entered with `fault`=1.
- Lock loss in `RUN`:
  - Stimulus: lock held low for 1 cycle.
  - Required: all `domain_rst`=1 and `n_ready`=1 within 3 cycles; `pll_rst` pulse follows. With the filter macro defined, there is no response.
- Wakeup drop in `RELEASE`:
  - Stimulus: `wakeup`=0.
  - Required: `IDLE` next edge, all resets asserted; the sequence restarts cleanly when `wakeup` returns to 1.
- Async reset in `SETTLE`:
  - Stimulus: `rst_in` pulse.
  - Required: outputs take reset values before the next edge; `state_dbg`=0.
